// File: rtl/debug_pkg.sv
// Shared types and sizing helpers for the debug snapshot UART dumper.
package debug_pkg;

  typedef enum logic [1:0] {
    SEC_PC   = 2'd0,
    SEC_REGS = 2'd1,
    SEC_MEM  = 2'd2,
    SEC_CNT  = 2'd3
  } section_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_WAIT  = 2'd2
  } ser_state_t;

  function automatic int unsigned bytes_per_word(input int unsigned bits, input int unsigned trama);
    return bits / trama;
  endfunction

  // Select width that stays at least one bit wide for single-entry spaces.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Splits one latched word into UART frames, LSB byte first, paced by tx_done.
module word_byte_serializer
  import debug_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              word_done
);
  localparam int unsigned BYTES_PER_WORD = bytes_per_word(WORD_W, BYTE_W);
  localparam int unsigned CNT_W          = addr_width(BYTES_PER_WORD);

  ser_state_t        state, state_nxt;
  logic [WORD_W-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]  byte_cnt, cnt_nxt;
  logic [BYTE_W-1:0] data_nxt;
  logic              start_nxt, done_nxt;
  logic              last_byte;

  assign last_byte = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SER_IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      byte_cnt  <= cnt_nxt;
      tx_start  <= start_nxt;
      tx_data   <= data_nxt;
      word_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SER_IDLE:  if (load) state_nxt = SER_START;
      SER_START: state_nxt = SER_WAIT;
      SER_WAIT:  if (tx_done) state_nxt = last_byte ? SER_IDLE : SER_START;
      default:   state_nxt = SER_IDLE;
    endcase
  end

  // tx_data is refreshed only when a new frame is about to launch.
  always_comb begin
    shift_nxt = shift_reg;
    cnt_nxt   = byte_cnt;
    data_nxt  = tx_data;
    start_nxt = (state_nxt == SER_START);
    done_nxt  = 1'b0;
    if (state == SER_IDLE && load) begin
      shift_nxt = word;
      cnt_nxt   = '0;
      data_nxt  = word[BYTE_W-1:0];
    end else if (state == SER_WAIT && tx_done) begin
      shift_nxt = shift_reg >> BYTE_W;
      cnt_nxt   = byte_cnt + CNT_W'(1);
      if (last_byte) done_nxt = 1'b1;
      else           data_nxt = shift_nxt[BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Walks PC, register bank, data memory and cycle counter, handing each word
// to the byte serializer for transmission over the UART.
module debug_dump_tx
  import debug_pkg::*;
#(
  parameter  int unsigned BITS_SIZE  = 32,
  parameter  int unsigned SIZE_TRAMA = 8,
  parameter  int unsigned NUM_REGS   = 32,
  parameter  int unsigned NUM_MEM    = 16,
  localparam int unsigned REG_AW     = addr_width(NUM_REGS),
  localparam int unsigned MEM_AW     = addr_width(NUM_MEM)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_dump,
  input  logic [BITS_SIZE-1:0]  i_pc,
  input  logic [BITS_SIZE-1:0]  i_clk_count,
  output logic [REG_AW-1:0]     o_reg_addr,
  input  logic [BITS_SIZE-1:0]  i_reg_data,
  output logic [MEM_AW-1:0]     o_mem_addr,
  input  logic [BITS_SIZE-1:0]  i_mem_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int unsigned IDX_W = (REG_AW > MEM_AW) ? REG_AW : MEM_AW;

  state_t            state, state_nxt;
  section_t          sec, sec_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [REG_AW-1:0] reg_addr_nxt;
  logic [MEM_AW-1:0] mem_addr_nxt;
  logic              busy_nxt, done_nxt;
  logic              load, word_done;
  logic [BITS_SIZE-1:0] word;

  assign load = (state == ST_LATCH);

  always_comb begin
    case (sec)
      SEC_PC:   word = i_pc;
      SEC_REGS: word = i_reg_data;
      SEC_MEM:  word = i_mem_data;
      default:  word = i_clk_count;
    endcase
  end

  word_byte_serializer #(
    .WORD_W (BITS_SIZE),
    .BYTE_W (SIZE_TRAMA)
  ) u_ser (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (load),
    .word      (word),
    .tx_done   (i_tx_done),
    .tx_start  (o_tx_start),
    .tx_data   (o_tx_data),
    .word_done (word_done)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      sec        <= SEC_PC;
      idx        <= '0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sec        <= sec_nxt;
      idx        <= idx_nxt;
      o_reg_addr <= reg_addr_nxt;
      o_mem_addr <= mem_addr_nxt;
      o_busy     <= busy_nxt;
      o_done     <= done_nxt;
    end
  end

  // State and section/index sequencing.
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (i_dump) begin
          state_nxt = ST_FETCH;
          sec_nxt   = SEC_PC;
          idx_nxt   = '0;
        end
      end
      ST_FETCH:  state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_START;
      ST_START:  state_nxt = ST_WAIT;
      ST_WAIT:   if (word_done) state_nxt = ST_NEXT;
      ST_NEXT: begin
        state_nxt = (sec == SEC_CNT) ? ST_FINISH : ST_FETCH;
        case (sec)
          SEC_PC: begin
            sec_nxt = SEC_REGS;
            idx_nxt = '0;
          end
          SEC_REGS: begin
            if (idx == IDX_W'(NUM_REGS - 1)) begin
              sec_nxt = SEC_MEM;
              idx_nxt = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
          SEC_MEM: begin
            if (idx == IDX_W'(NUM_MEM - 1)) begin
              sec_nxt = SEC_CNT;
              idx_nxt = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
          default: begin
            sec_nxt = SEC_PC;
            idx_nxt = '0;
          end
        endcase
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    busy_nxt     = (state_nxt != ST_IDLE) && (state_nxt != ST_FINISH);
    done_nxt     = (state_nxt == ST_FINISH);
    reg_addr_nxt = o_reg_addr;
    mem_addr_nxt = o_mem_addr;
    if (state_nxt == ST_IDLE) begin
      reg_addr_nxt = '0;
      mem_addr_nxt = '0;
    end else if (state_nxt == ST_FETCH) begin
      if (sec_nxt == SEC_REGS) reg_addr_nxt = REG_AW'(idx_nxt);
      if (sec_nxt == SEC_MEM)  mem_addr_nxt = MEM_AW'(idx_nxt);
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx with a small register/memory/UART model.
module tb_debug_dump_tx;
  localparam int unsigned W      = 32;
  localparam int unsigned T      = 8;
  localparam int unsigned NREG   = 2;
  localparam int unsigned NMEM   = 1;
  localparam int unsigned FRAMES = (W / T) * (2 + NREG + NMEM);
  localparam int          MAX_CYC = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          dump;
  logic [W-1:0]  pc;
  logic [W-1:0]  clk_count;
  logic [0:0]    reg_addr;
  logic [W-1:0]  reg_data;
  logic [0:0]    mem_addr;
  logic [W-1:0]  mem_data;
  logic          tx_done;
  logic          tx_force;
  logic          tx_model;
  logic          tx_start;
  logic [T-1:0]  tx_data;
  logic          busy;
  logic          done;
  int            tx_timer;

  logic [W-1:0]  regs [2];
  logic [W-1:0]  mems [2];

  int errors = 0;
  int checks = 0;
  logic [T-1:0] exp_q [$];
  logic [T-1:0] got_q [$];
  logic [0:0]   reg_at_q [$];
  logic [0:0]   mem_at_q [$];

  always #5 clk = ~clk;

  debug_dump_tx #(
    .BITS_SIZE  (W),
    .SIZE_TRAMA (T),
    .NUM_REGS   (NREG),
    .NUM_MEM    (NMEM)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_dump      (dump),
    .i_pc        (pc),
    .i_clk_count (clk_count),
    .o_reg_addr  (reg_addr),
    .i_reg_data  (reg_data),
    .o_mem_addr  (mem_addr),
    .i_mem_data  (mem_data),
    .i_tx_done   (tx_done),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Synchronous read ports: data valid one cycle after the address.
  always @(posedge clk) begin
    reg_data <= regs[reg_addr];
    mem_data <= mems[mem_addr];
  end

  // UART stand-in: tx_done pulses 5 cycles after each tx_start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_timer <= 0;
      tx_model <= 1'b0;
    end else begin
      tx_model <= 1'b0;
      if (tx_start) tx_timer <= 4;
      else if (tx_timer > 0) begin
        tx_timer <= tx_timer - 1;
        if (tx_timer == 1) tx_model <= 1'b1;
      end
    end
  end
  assign tx_done = tx_model | tx_force;

  task automatic push_snapshot(input logic [W-1:0] pc_v);
    logic [W-1:0] words [5];
    words = '{pc_v, regs[0], regs[1], mems[0], clk_count};
    exp_q.delete();
    for (int i = 0; i < 5; i++)
      for (int b = 0; b < int'(W / T); b++)
        exp_q.push_back(words[i][b*T +: T]);
  endtask

  // Records frames until a done pulse plus a tail; hook 1 re-pulses dump, hook 2 alters pc.
  task automatic capture(input int hook_frame, input int hook_kind,
                         output int n_done, output bit busy_after, output bit tmo);
    int cyc;
    int post;
    cyc = 0; post = -1; n_done = 0; busy_after = 1'b1; tmo = 1'b0;
    got_q.delete(); reg_at_q.delete(); mem_at_q.delete();
    while (1) begin
      @(negedge clk);
      cyc++;
      dump = 1'b0;
      tx_force = 1'b0;
      if (tx_start) begin
        got_q.push_back(tx_data);
        reg_at_q.push_back(reg_addr);
        mem_at_q.push_back(mem_addr);
        if (got_q.size() == hook_frame) begin
          if (hook_kind == 1) dump = 1'b1;
          if (hook_kind == 2) pc = 32'h55667788;
        end
      end
      if (post >= 0) begin
        post++;
        if (post == 1) busy_after = busy;
      end
      if (done) begin
        n_done++;
        if (post < 0) post = 0;
      end
      if (post >= 12) break;
      if (cyc >= MAX_CYC) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (reg_addr !== 1'b0) begin errors++; $display("FAIL reset_reg_addr got=%h exp=0", reg_addr); end
    checks++; if (mem_addr !== 1'b0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_dump();
    int nd; bit ba, tmo; logic [T-1:0] g, e;
    push_snapshot(pc);
    @(negedge clk); dump = 1'b1;
    capture(0, 0, nd, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL single_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != FRAMES) begin errors++; $display("FAIL single_frames got=%0d exp=%0d", got_q.size(), FRAMES); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++;
      if (i >= 4 && i < 12 && reg_at_q[i] !== ((i < 8) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL single_reg_addr frame%0d got=%h exp=%0d", i, reg_at_q[i], (i < 8) ? 0 : 1);
      end
      if (i >= 12 && mem_at_q[i] !== 1'b0) begin
        errors++; $display("FAIL single_mem_addr frame%0d got=%h exp=0", i, mem_at_q[i]);
      end
    end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL single_byte%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", nd); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_redump_ignored();
    int nd; bit ba, tmo; logic [T-1:0] g, e;
    push_snapshot(pc);
    @(negedge clk); dump = 1'b1;
    capture(3, 1, nd, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL redump_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != FRAMES) begin errors++; $display("FAIL redump_frames got=%0d exp=%0d", got_q.size(), FRAMES); end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL redump_byte%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL redump_done_count got=%0d exp=1", nd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL redump_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_pc_change();
    int nd; bit ba, tmo; logic [T-1:0] g, e; logic [W-1:0] pc_save;
    pc_save = pc;
    push_snapshot(pc);
    @(negedge clk); dump = 1'b1;
    capture(1, 2, nd, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL pcchg_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != FRAMES) begin errors++; $display("FAIL pcchg_frames got=%0d exp=%0d", got_q.size(), FRAMES); end
    for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL pcchg_byte%0d got=%h exp=%h", i, g, e); end
    end
    pc = pc_save;
  endtask

  task automatic test_reset_mid();
    int n, cyc, nd; bit ba, tmo; logic [T-1:0] g, e;
    n = 0; cyc = 0;
    @(negedge clk); dump = 1'b1;
    @(negedge clk); dump = 1'b0;
    while (n < 9 && cyc < MAX_CYC) begin
      if (tx_start) n++;
      if (n < 9) begin @(negedge clk); cyc++; end
    end
    checks++; if (n != 9) begin errors++; $display("FAIL rstmid_reach got=%0d exp=9", n); end
    repeat (2) @(negedge clk);
    checks++; if (reg_addr !== 1'b1) begin errors++; $display("FAIL rstmid_pre_reg_addr got=%h exp=1", reg_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start got=%b exp=0", tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (reg_addr !== 1'b0) begin errors++; $display("FAIL rstmid_reg_addr got=%h exp=0", reg_addr); end
    checks++; if (mem_addr !== 1'b0) begin errors++; $display("FAIL rstmid_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data got=%h exp=00", tx_data); end
    @(negedge clk); rst = 1'b0;
    push_snapshot(pc);
    @(negedge clk); dump = 1'b1;
    capture(0, 0, nd, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rstmid_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != FRAMES) begin errors++; $display("FAIL rstmid_frames got=%0d exp=%0d", got_q.size(), FRAMES); end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL rstmid_done_count got=%0d exp=1", nd); end
  endtask

  task automatic test_idle_tx_done();
    int ns, nb, nd; bit ba, tmo; logic [T-1:0] g, e;
    ns = 0; nb = 0;
    @(negedge clk); tx_force = 1'b1;
    @(negedge clk); tx_force = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tx_start) ns++;
      if (busy) nb++;
    end
    checks++; if (ns != 0) begin errors++; $display("FAIL idle_done_frames got=%0d exp=0", ns); end
    checks++; if (nb != 0) begin errors++; $display("FAIL idle_done_busy got=%0d exp=0", nb); end
    push_snapshot(pc);
    @(negedge clk); dump = 1'b1; tx_force = 1'b1;
    capture(0, 0, nd, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL both_timeout got=timeout exp=done"); end
    checks++; if (got_q.size() != FRAMES) begin errors++; $display("FAIL both_frames got=%0d exp=%0d", got_q.size(), FRAMES); end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL both_byte%0d got=%h exp=%h", i, g, e); end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL both_done_count got=%0d exp=1", nd); end
  endtask

  initial begin
    dump      = 1'b0;
    tx_force  = 1'b0;
    pc        = 32'h11223344;
    clk_count = 32'h00000007;
    regs[0]   = 32'hAABBCCDD;
    regs[1]   = 32'h01020304;
    mems[0]   = 32'hDEADBEEF;
    mems[1]   = 32'h00000000;
    test_reset();
    test_single_dump();
    test_redump_ignored();
    test_pc_change();
    test_reset_mid();
    test_idle_tx_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
